// File: rtl/reg_bus_arb.sv
// N-to-1 arbiter for the NOP/RD/WR register bus with pipelined read-data return.
// Define REG_ARB_FIXED_PRIO_EN for fixed priority (lowest index wins); default is round-robin.
module reg_bus_arb #(
    parameter int NREQ   = 4,
    parameter int DWIDTH = 8,
    parameter int AWIDTH = 8,
    parameter int RD_LAT = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [2*NREQ-1:0]        up_op,
    input  logic [AWIDTH*NREQ-1:0]   up_addr,
    input  logic [DWIDTH*NREQ-1:0]   up_wdata,
    output logic [NREQ-1:0]          up_gnt,
    output logic [NREQ-1:0]          up_rvalid,
    output logic [DWIDTH-1:0]        up_rdata,
    output logic [1:0]               dn_op,
    output logic [AWIDTH-1:0]        dn_addr,
    output logic [DWIDTH-1:0]        dn_wdata,
    input  logic [DWIDTH-1:0]        dn_rdata
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [1:0] OP_NOP = 2'b00;
    localparam logic [1:0] OP_RD  = 2'b01;
    localparam logic [1:0] OP_WR  = 2'b10;

    // Illegal op 11 is simply not a request, so it can never win or block.
    logic [NREQ-1:0] req;
    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_req
            assign req[gi] = (up_op[2*gi +: 2] == OP_RD) || (up_op[2*gi +: 2] == OP_WR);
        end
    endgenerate

    logic          gnt_any;
    logic [IW-1:0] win_idx;

`ifdef REG_ARB_FIXED_PRIO_EN
    always_comb begin
        gnt_any = 1'b0;
        win_idx = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (req[k] && !rst) begin
                gnt_any = 1'b1;
                win_idx = IW'(k);
            end
        end
    end
`else
    logic [IW-1:0] ptr_reg;
    logic [IW-1:0] cand;

    // Scan downward so the last hit is the nearest channel after the pointer.
    always_comb begin
        gnt_any = 1'b0;
        win_idx = '0;
        cand    = '0;
        for (int k = NREQ; k >= 1; k--) begin
            cand = IW'((int'(ptr_reg) + k) % NREQ);
            if (req[cand] && !rst) begin
                gnt_any = 1'b1;
                win_idx = cand;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_reg <= IW'(NREQ - 1);
        end else if (gnt_any) begin
            ptr_reg <= win_idx;
        end
    end
`endif

    assign up_gnt = gnt_any ? (NREQ'(1) << win_idx) : '0;

    logic [1:0]        win_op;
    logic [AWIDTH-1:0] win_addr;
    logic [DWIDTH-1:0] win_wdata;

    always_comb begin
        win_op    = up_op[2*int'(win_idx) +: 2];
        win_addr  = up_addr[AWIDTH*int'(win_idx) +: AWIDTH];
        win_wdata = up_wdata[DWIDTH*int'(win_idx) +: DWIDTH];
    end

    // Stage 0 is aligned with the downstream RD cycle; stage RD_LAT with dn_rdata.
    logic [RD_LAT:0] vld_reg;
    logic [IW-1:0]   id_reg [RD_LAT+1];

    always_ff @(posedge clk) begin
        if (rst) begin
            dn_op      <= OP_NOP;
            dn_addr    <= '0;
            dn_wdata   <= '0;
            vld_reg[0] <= 1'b0;
            id_reg[0]  <= '0;
        end else begin
            dn_op      <= gnt_any ? win_op : OP_NOP;
            vld_reg[0] <= gnt_any && (win_op == OP_RD);
            id_reg[0]  <= win_idx;
            if (gnt_any) begin
                dn_addr  <= win_addr;
                dn_wdata <= win_wdata;
            end
        end
    end

    generate
        for (genvar gi = 1; gi <= RD_LAT; gi++) begin : g_pipe
            always_ff @(posedge clk) begin
                if (rst) begin
                    vld_reg[gi] <= 1'b0;
                    id_reg[gi]  <= '0;
                end else begin
                    vld_reg[gi] <= vld_reg[gi-1];
                    id_reg[gi]  <= id_reg[gi-1];
                end
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            up_rvalid <= '0;
            up_rdata  <= '0;
        end else begin
            up_rvalid <= vld_reg[RD_LAT] ? (NREQ'(1) << id_reg[RD_LAT]) : '0;
            if (vld_reg[RD_LAT]) begin
                up_rdata <= dn_rdata;
            end
        end
    end

endmodule
